// File: rtl/mux_scan_nx1.sv
// Registered N-to-1 channel multiplexer with a built-in sequencer.
// Modes: manual select, continuous scan, single triggered sweep, and hold.
module mux_scan_nx1 #(
  parameter int N_IN   = 16,
  parameter int DATA_W = 1,
  parameter int DWELL  = 1,
  localparam int SEL_W = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_IN*DATA_W-1:0]   in,
  input  logic [1:0]               mode,
  input  logic [SEL_W-1:0]         sel_in,
  input  logic                     start,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     out_valid,
  output logic                     sel_err,
  output logic                     wrap,
  output logic                     busy,
  output logic                     done
);

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_SWEEP  = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam int              N_SLOT  = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] CH_LAST = SEL_W'(N_IN - 1);
  localparam logic [15:0]     DW_LAST = 16'(DWELL - 1);

  logic [0:0]       state;
  logic [SEL_W-1:0] ch;
  logic [15:0]      dw;
  logic [1:0]       mode_q;
  logic             mode_chg;
  logic             sel_bad;

  // Channel table padded to a power of two; unused slots read as zero and
  // are flagged invalid, so an out-of-range select yields 0 naturally.
  logic [DATA_W-1:0] chan [N_SLOT];
  logic [N_SLOT-1:0] slot_ok;

  for (genvar k = 0; k < N_SLOT; k++) begin : g_slot
    if (k < N_IN) begin : g_used
      assign chan[k]    = in[k*DATA_W +: DATA_W];
      assign slot_ok[k] = 1'b1;
    end else begin : g_pad
      assign chan[k]    = '0;
      assign slot_ok[k] = 1'b0;
    end
  end

  assign sel_bad  = ~slot_ok[sel_in];
  assign mode_chg = (mode != mode_q);

  // NOTE: every register below uses non-blocking assignment so all state
  // updates see the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ch        <= '0;
      dw        <= '0;
      mode_q    <= MODE_MANUAL;
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
      wrap      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      mode_q  <= mode;
      wrap    <= 1'b0;
      done    <= 1'b0;
      sel_err <= 1'b0;

      // Manual presentation ignores the sequencer entirely, including on the
      // edge that switches into manual.
      if (mode == MODE_MANUAL) begin
        out_sel   <= sel_in;
        out_data  <= chan[sel_in];
        out_valid <= 1'b1;
        sel_err   <= sel_bad;
      end

      if (mode_chg) begin
        // A mode change resets the sequencer and aborts any sweep silently;
        // scan restarts immediately so channel 0 is presented on the next edge.
        ch    <= '0;
        dw    <= '0;
        busy  <= 1'b0;
        state <= (mode == MODE_SCAN) ? RUN : IDLE;
        if (mode != MODE_MANUAL) out_valid <= 1'b0;
      end else begin
        unique case (mode)
          MODE_MANUAL: begin
            state <= IDLE;
          end
          MODE_HOLD: begin
            out_valid <= 1'b0;
          end
          MODE_SCAN, MODE_SWEEP: begin
            if (state == RUN) begin
              out_data  <= chan[ch];
              out_sel   <= ch;
              out_valid <= 1'b1;
              if (dw == DW_LAST) begin
                dw <= '0;
                if (ch == CH_LAST) begin
                  ch <= '0;
                  if (mode == MODE_SCAN) begin
                    wrap <= 1'b1;
                  end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                  end
                end else begin
                  ch <= ch + SEL_W'(1);
                end
              end else begin
                dw <= dw + 16'd1;
              end
            end else begin
              out_valid <= 1'b0;
              if (mode == MODE_SCAN) begin
                state <= RUN;
              end else if (start) begin
                state <= RUN;
                ch    <= '0;
                dw    <= '0;
                busy  <= 1'b1;
              end
            end
          end
          default: begin
            out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
